// File: rtl/crc8_frame_checker.sv
// CRC-8 (poly 0x07, MSB-first) frame checker: consumes a word stream whose last
// word is the received CRC, then presents residue, length and error status.
module crc8_frame_checker #(
    parameter logic [7:0] INIT   = 8'h00,
    parameter int         MAXLEN = 255
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  inData,
    input  logic        inValid,
    input  logic        inLast,
    output logic        inReady,
    output logic        resValid,
    input  logic        resReady,
    output logic        resOk,
    output logic [7:0]  resResidue,
    output logic [7:0]  resLen,
    output logic        resLenErr,
    output logic [15:0] errCount
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;
    localparam logic [8:0] MAXLEN9   = 9'(MAXLEN);

    logic [1:0]  state_q, state_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  len_q, len_d;
    logic        err_q, err_d;
    logic        in_ready_q, in_ready_d;
    logic        res_valid_q, res_valid_d;
    logic        res_ok_q, res_ok_d;
    logic [7:0]  res_residue_q, res_residue_d;
    logic [7:0]  res_len_q, res_len_d;
    logic        res_len_err_q, res_len_err_d;
    logic [15:0] err_count_q, err_count_d;

    function automatic logic [7:0] step8(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    logic       accept;
    logic [7:0] crc_upd;
    logic [8:0] len_inc;
    logic [7:0] len_new;
    logic       err_new;

    always_comb begin
        accept  = inValid && in_ready_q;
        crc_upd = step8(crc_q ^ inData);
        len_inc = {1'b0, len_q} + 9'd1;
        // The first word of a frame can only be a runt error, never an overlong one.
        if (state_q == ST_IDLE) begin
            len_new = 8'd1;
            err_new = inLast;
        end else begin
            len_new = len_inc[8] ? 8'hFF : len_inc[7:0];
            err_new = err_q || (len_inc > MAXLEN9);
        end

        state_d       = state_q;
        crc_d         = crc_q;
        len_d         = len_q;
        err_d         = err_q;
        res_valid_d   = res_valid_q;
        res_ok_d      = res_ok_q;
        res_residue_d = res_residue_q;
        res_len_d     = res_len_q;
        res_len_err_d = res_len_err_q;
        err_count_d   = err_count_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    crc_d = crc_upd;
                    len_d = len_new;
                    err_d = err_new;
                    if (inLast) begin
                        state_d       = ST_RESULT;
                        res_valid_d   = 1'b1;
                        res_residue_d = crc_upd;
                        res_len_d     = len_new;
                        res_len_err_d = err_new;
                        res_ok_d      = (crc_upd == 8'h00) && !err_new;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RESULT: begin
                if (resReady) begin
                    state_d     = ST_IDLE;
                    crc_d       = INIT;
                    len_d       = 8'd0;
                    err_d       = 1'b0;
                    res_valid_d = 1'b0;
                    if (!res_ok_q && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                crc_d   = INIT;
                len_d   = 8'd0;
                err_d   = 1'b0;
            end
        endcase

        in_ready_d = (state_d != ST_RESULT);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_IDLE;
            crc_q         <= INIT;
            len_q         <= 8'd0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ok_q      <= 1'b0;
            res_residue_q <= 8'h00;
            res_len_q     <= 8'd0;
            res_len_err_q <= 1'b0;
            err_count_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            err_q         <= err_d;
            in_ready_q    <= in_ready_d;
            res_valid_q   <= res_valid_d;
            res_ok_q      <= res_ok_d;
            res_residue_q <= res_residue_d;
            res_len_q     <= res_len_d;
            res_len_err_q <= res_len_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign inReady    = in_ready_q;
    assign resValid   = res_valid_q;
    assign resOk      = res_ok_q;
    assign resResidue = res_residue_q;
    assign resLen     = res_len_q;
    assign resLenErr  = res_len_err_q;
    assign errCount   = err_count_q;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Bench for crc8_frame_checker: table vectors, hand-written corner sequences and
// random frames checked against a table-driven CRC model (default and MAXLEN=4 instances).
module tb_crc8_frame_checker;

    logic        clk;
    logic        rstN;
    logic [7:0]  inData;
    logic        inValid;
    logic        inLast;
    logic        resReady;

    logic        inReady, resValid, resOk, resLenErr;
    logic [7:0]  resResidue, resLen;
    logic [15:0] errCount;
    logic        inReady4, resValid4, resOk4, resLenErr4;
    logic [7:0]  resResidue4, resLen4;
    logic [15:0] errCount4;

    crc8_frame_checker dut (
        .clk(clk), .rstN(rstN), .inData(inData), .inValid(inValid), .inLast(inLast),
        .inReady(inReady), .resValid(resValid), .resReady(resReady), .resOk(resOk),
        .resResidue(resResidue), .resLen(resLen), .resLenErr(resLenErr), .errCount(errCount)
    );

    crc8_frame_checker #(.MAXLEN(4)) dut4 (
        .clk(clk), .rstN(rstN), .inData(inData), .inValid(inValid), .inLast(inLast),
        .inReady(inReady4), .resValid(resValid4), .resReady(resReady), .resOk(resOk4),
        .resResidue(resResidue4), .resLen(resLen4), .resLenErr(resLenErr4), .errCount(errCount4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ok;
        logic [7:0] res;
        logic [7:0] len;
        logic       err;
        logic       ok4;
        logic       err4;
    } exp_t;

    typedef struct packed {
        logic [7:0]  n;
        logic [95:0] bytes;
        logic [7:0]  hold;
        exp_t        e;
    } vec_t;

    int         n_vec = 0;
    int         n_bad = 0;
    int         exp_errcnt = 0;
    int         exp_errcnt4 = 0;
    logic [7:0] crc_tbl [256];
    logic [7:0] frame_q [$];
    vec_t       vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Remainder of (i * x^8) modulo x^8+x^2+x+1, by GF(2) long division.
    task automatic build_table();
        for (int i = 0; i < 256; i++) begin
            int v;
            v = i << 8;
            for (int b = 15; b >= 8; b--) begin
                if (((v >> b) & 1) == 1) v = v ^ (32'h107 << (b - 8));
            end
            crc_tbl[i] = v[7:0];
        end
    endtask

    function automatic exp_t model();
        exp_t       e;
        logic [7:0] c;
        int         n;
        c = 8'h00;
        foreach (frame_q[k]) c = crc_tbl[c ^ frame_q[k]];
        n      = frame_q.size();
        e.res  = c;
        e.len  = (n > 255) ? 8'hFF : n[7:0];
        e.err  = (n < 2) || (n > 255);
        e.err4 = (n < 2) || (n > 4);
        e.ok   = (c == 8'h00) && !e.err;
        e.ok4  = (c == 8'h00) && !e.err4;
        return e;
    endfunction

    task automatic send_word(input logic [7:0] d, input logic last);
        int t;
        @(negedge clk);
        inData = d; inValid = 1'b1; inLast = last;
        t = 0;
        while (!inReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0; inLast = 1'b0;
    endtask

    task automatic send_frame(input logic gaps);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    inData = 8'($urandom); inLast = 1'($urandom);
                end
            end
            send_word(frame_q[i], i == frame_q.size() - 1);
        end
    endtask

    // Called #1 after the edge that accepted the last word.
    task automatic finish_frame(input exp_t e, input int hold);
        logic [17:0] snap;
        chk("latency_valid", 32'(resValid), 32'd1);
        chk("ok", 32'(resOk), 32'(e.ok));
        chk("residue", 32'(resResidue), 32'(e.res));
        chk("len", 32'(resLen), 32'(e.len));
        chk("len_err", 32'(resLenErr), 32'(e.err));
        chk("ok_m4", 32'(resOk4), 32'(e.ok4));
        chk("len_err_m4", 32'(resLenErr4), 32'(e.err4));
        chk("len_m4", 32'(resLen4), 32'(e.len));
        snap = {resOk, resResidue, resLen, resLenErr};
        // A junk last-word offered while the result waits must be refused.
        inValid = 1'b1; inData = 8'($urandom); inLast = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(inReady), 32'd0);
            chk("hold_fields", 32'({resValid, resOk, resResidue, resLen, resLenErr}), 32'({1'b1, snap}));
        end
        @(negedge clk);
        chk("hs_in_ready", 32'(inReady), 32'd0);
        resReady = 1'b1;
        @(posedge clk);
        #1;
        resReady = 1'b0; inValid = 1'b0; inLast = 1'b0;
        if (!e.ok && exp_errcnt < 16'hFFFF) exp_errcnt++;
        if (!e.ok4 && exp_errcnt4 < 16'hFFFF) exp_errcnt4++;
        chk("post_hs_valid", 32'(resValid), 32'd0);
        chk("post_hs_in_ready", 32'(inReady), 32'd1);
        chk("err_count", 32'(errCount), 32'(exp_errcnt));
        chk("err_count_m4", 32'(errCount4), 32'(exp_errcnt4));
        $display("frame len=%0d residue=%02h ok=%0b lenerr=%0b errcount=%0d",
                 e.len, e.res, e.ok, e.err, exp_errcnt);
    endtask

    task automatic run_frame(input exp_t e, input int hold, input logic gaps);
        send_frame(gaps);
        finish_frame(e, hold);
    endtask

    task automatic load_vec(input vec_t v);
        frame_q.delete();
        for (int i = 0; i < int'(v.n); i++) frame_q.push_back(v.bytes[i*8 +: 8]);
    endtask

    initial begin
        build_table();
        rstN = 1'b0; inData = 8'h00; inValid = 1'b0; inLast = 1'b0; resReady = 1'b0;

        //            n      bytes (byte0 in LSBs)                 hold   ok  res    len    err  ok4  err4
        vecs[0] = '{8'd10, 96'h0000_F439_3837_3635_3433_3231, 8'd0, '{1'b1, 8'h00, 8'd10, 1'b0, 1'b0, 1'b1}};
        vecs[1] = '{8'd10, 96'h0000_F539_3837_3635_3433_3231, 8'd5, '{1'b0, 8'h07, 8'd10, 1'b0, 1'b0, 1'b1}};
        vecs[2] = '{8'd1,  96'h00,                            8'd1, '{1'b0, 8'h00, 8'd1,  1'b1, 1'b0, 1'b1}};
        vecs[3] = '{8'd6,  96'h00,                            8'd0, '{1'b1, 8'h00, 8'd6,  1'b0, 1'b0, 1'b1}};
        vecs[4] = '{8'd2,  96'h0701,                          8'd2, '{1'b1, 8'h00, 8'd2,  1'b0, 1'b1, 1'b0}};
        vecs[5] = '{8'd1,  96'hFF,                            8'd0, '{1'b0, 8'hF3, 8'd1,  1'b1, 1'b0, 1'b1}};

        #1;
        chk("rst_in_ready", 32'(inReady), 32'd0);
        chk("rst_outputs", 32'({resValid, resOk, resResidue, resLen, resLenErr}), 32'd0);
        chk("rst_err_count", 32'(errCount), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(inReady), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 32'(inReady), 32'd1);

        for (int i = 0; i < 6; i++) begin
            load_vec(vecs[i]);
            run_frame(vecs[i].e, int'(vecs[i].hold), 1'b0);
        end

        // Reset three words into a frame: nothing reported, then a clean frame.
        load_vec(vecs[0]);
        for (int i = 0; i < 3; i++) send_word(frame_q[i], 1'b0);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        exp_errcnt = 0; exp_errcnt4 = 0;
        chk("midrst_in_ready", 32'(inReady), 32'd0);
        chk("midrst_valid", 32'(resValid), 32'd0);
        chk("midrst_err_count", 32'(errCount), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(resValid), 32'd0);
        end
        run_frame(vecs[0].e, 0, 1'b1);

        // Overlong frame on the default instance: length saturates at 255.
        frame_q.delete();
        for (int i = 0; i < 257; i++) frame_q.push_back(8'($urandom));
        run_frame(model(), 1, 1'b0);

        // Random frames, about half carrying their correct CRC.
        for (int f = 0; f < 40; f++) begin
            int n;
            logic [7:0] c;
            frame_q.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                c = 8'h00;
                foreach (frame_q[k]) c = crc_tbl[c ^ frame_q[k]];
                frame_q.push_back(c);
            end
            run_frame(model(), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
